// File: rtl/issue_pkg.sv
// Shared definitions for the dual-issue sequencer: opcodes, FSM states, NOP and decode helpers.
package issue_pkg;

    localparam int DATA_W = 32;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [DATA_W-1:0] NOP = 32'h0000_0013;

    typedef enum logic {
        READY = 1'b0,
        SPLIT = 1'b1
    } state_t;

    // Stores and branches have no destination register.
    function automatic logic writes_rd(input logic [6:0] op);
        return !((op == OP_STORE) || (op == OP_BRANCH));
    endfunction

    // LUI, AUIPC and JAL take no rs1 operand.
    function automatic logic uses_rs1(input logic [6:0] op);
        return !((op == OP_LUI) || (op == OP_AUIPC) || (op == OP_JAL));
    endfunction

    // Only register-register ops, stores and branches read rs2.
    function automatic logic uses_rs2(input logic [6:0] op);
        return (op == OP_REG) || (op == OP_STORE) || (op == OP_BRANCH);
    endfunction

endpackage

// File: rtl/hazard_check.sv
// Combinational RAW/WAW detection between the older and younger instruction of a pair.
module hazard_check
    import issue_pkg::*;
(
    input  logic [DATA_W-1:0] instr0,
    input  logic [DATA_W-1:0] instr1,
    output logic              hazard
);

    logic [6:0] op0;
    logic [6:0] op1;
    logic [4:0] rd0;
    logic [4:0] rd1;
    logic [4:0] rs1_1;
    logic [4:0] rs2_1;

    assign op0   = instr0[6:0];
    assign op1   = instr1[6:0];
    assign rd0   = instr0[11:7];
    assign rd1   = instr1[11:7];
    assign rs1_1 = instr1[19:15];
    assign rs2_1 = instr1[24:20];

    // x0 is never a real producer, so a zero rd0 masks every match.
    always_comb begin
        hazard = 1'b0;
        if (writes_rd(op0) && (rd0 != 5'd0)) begin
            if (uses_rs1(op1) && (rs1_1 == rd0)) hazard = 1'b1;
            if (uses_rs2(op1) && (rs2_1 == rd0)) hazard = 1'b1;
            if (writes_rd(op1) && (rd1 == rd0))  hazard = 1'b1;
        end
    end

endmodule

// File: rtl/issue_sequencer.sv
// Dual-issue sequencer: issues an instruction pair to two datapaths, splitting dependent pairs over two cycles.
module issue_sequencer
    import issue_pkg::*;
(
    input  logic              clk,
    input  logic              n_rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] instr0,
    input  logic [DATA_W-1:0] instr1,
    input  logic              instr1_valid,
    input  logic              stall,
    output logic              dp1_en,
    output logic              dp2_en,
    output logic [DATA_W-1:0] dp1_instr,
    output logic [DATA_W-1:0] dp2_instr,
    output logic [15:0]       issue_count,
    output logic [7:0]        split_count
);

    state_t            state;
    state_t            state_nxt;
    logic              hazard;
    logic              accept;
    logic              dp1_en_nxt;
    logic              dp2_en_nxt;
    logic [DATA_W-1:0] dp1_instr_nxt;
    logic [DATA_W-1:0] dp2_instr_nxt;
    logic [DATA_W-1:0] held_instr;
    logic [DATA_W-1:0] held_instr_nxt;
    logic              split_inc;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    hazard_check u_hazard_check (
        .instr0 (instr0),
        .instr1 (instr1),
        .hazard (hazard)
    );

    // Next-state and next-issue decode; outputs hold their last instruction when nothing issues.
    always_comb begin
        state_nxt      = state;
        in_ready       = n_rst && (state == READY) && !stall;
        accept         = in_valid && in_ready;
        dp1_en_nxt     = 1'b0;
        dp2_en_nxt     = 1'b0;
        dp1_instr_nxt  = dp1_instr;
        dp2_instr_nxt  = dp2_instr;
        held_instr_nxt = held_instr;
        split_inc      = 1'b0;
        case (state)
            READY: begin
                if (accept) begin
                    dp1_en_nxt    = 1'b1;
                    dp1_instr_nxt = instr0;
                    if (instr1_valid) begin
                        if (hazard) begin
                            held_instr_nxt = instr1;
                            split_inc      = 1'b1;
                            state_nxt      = SPLIT;
                        end else begin
                            dp2_en_nxt    = 1'b1;
                            dp2_instr_nxt = instr1;
                        end
                    end
                end
            end
            SPLIT: begin
                if (!stall) begin
                    dp2_en_nxt    = 1'b1;
                    dp2_instr_nxt = held_instr;
                    state_nxt     = READY;
                end
            end
            default: state_nxt = READY;
        endcase
    end

    // State, issue registers and counters; reset drops any pending second half.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= READY;
            dp1_en      <= 1'b0;
            dp2_en      <= 1'b0;
            dp1_instr   <= NOP;
            dp2_instr   <= NOP;
            held_instr  <= '0;
            issue_count <= '0;
            split_count <= '0;
        end else begin
            state       <= state_nxt;
            dp1_en      <= dp1_en_nxt;
            dp2_en      <= dp2_en_nxt;
            dp1_instr   <= dp1_instr_nxt;
            dp2_instr   <= dp2_instr_nxt;
            held_instr  <= held_instr_nxt;
            issue_count <= issue_count + {15'd0, dp1_en_nxt} + {15'd0, dp2_en_nxt};
            if (split_inc) split_count <= sat_inc8(split_count);
        end
    end

endmodule

// File: doc/issue_sequencer.md
ISSUE_SEQUENCER -- requirements
Module: issue_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 n_rst  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  instruction pair available from the queue.
REQ-005 in_ready  output  1  sequencer accepts the pair this cycle (combinational).
REQ-006 instr0  input  32  older instruction of the pair.
REQ-007 instr1  input  32  younger instruction of the pair.
REQ-008 instr1_valid  input  1  instr1 is meaningful; 0 means single instruction.
REQ-009 stall  input  1  hold request from downstream.
REQ-010 dp1_en, dp2_en  output  1 each  datapath enables (registered).
REQ-011 dp1_instr, dp2_instr  output  32 each  instruction issued to each datapath (registered).
REQ-012 issue_count  output  16  instructions issued, wraps at 0xFFFF->0.
REQ-013 split_count  output  8  hazard splits, saturates at 0xFF.

Function
REQ-014 A pair SHALL be accepted when in_valid && in_ready; in_ready = (state==READY) && !stall.
REQ-015 The FSM SHALL have two states: READY and SPLIT.
REQ-016 Decode per instruction: writes_rd = 0 for opcodes 0100011 (store) and 1100011 (branch), else 1; uses_rs1 = 0 for 0110111, 0010111 and 1101111, else 1; uses_rs2 = 1 only for 0110011, 0100011 and 1100011.
REQ-017 A hazard SHALL exist if instr0 writes a nonzero rd and one of these holds: instr1 uses rs1 equal to that rd (RAW); instr1 uses rs2 equal to that rd (RAW); instr1 writes an equal rd (WAW).
REQ-018 Register x0 SHALL never produce a hazard.
REQ-019 On accept with instr1_valid=0: the next cycle SHALL show dp1_en=1, dp1_instr=instr0, dp2_en=0; state stays READY.
REQ-020 On accept with no hazard: the next cycle SHALL show dp1_en=dp2_en=1, dp1_instr=instr0, dp2_instr=instr1; state stays READY.
REQ-021 On accept with a hazard: the next cycle SHALL show dp1_en=1 with instr0 and dp2_en=0; instr1 is latched; state goes to SPLIT; split_count increments.
REQ-022 In SPLIT with stall=0: the next cycle SHALL show dp2_en=1, dp2_instr=latched instr1, dp1_en=0; state returns to READY.
REQ-023 In SPLIT with stall=1: the state SHALL remain SPLIT and the latched instr1 is held.
REQ-024 in_ready SHALL be 0 throughout SPLIT, so no new pair is accepted until the second half issues.
REQ-025 In any cycle with no issue (no accept, or stall), both enables SHALL be 0 in the following cycle; dp*_instr hold their last values.
REQ-026 issue_count SHALL add the number of enables asserted in each issue (0, 1 or 2) and wrap modulo 2^16.
REQ-027 Latency from accept to the first enable SHALL be exactly 1 cycle.

Reset
REQ-028 While n_rst=0: state=READY, dp1_en=dp2_en=0, dp1_instr=dp2_instr=0x00000013 (NOP), issue_count=0, split_count=0, latched instr1 cleared.
REQ-029 A reset asserted mid-SPLIT SHALL discard the pending instr1, with no issue after release.
REQ-030 in_ready SHALL be 0 while n_rst=0.

Structure
REQ-031 A shared package issue_pkg SHALL hold the opcode constants, the state enum (READY, SPLIT) and the NOP constant.
REQ-032 Decode and hazard detection SHALL be a combinational sub-module hazard_check (instr0, instr1 -> hazard).

Verification
REQ-033 Independent pair: 0x003100B3 (add x1,x2,x3) then 0x00838333 (add x6,x7,x8) -> next cycle both enables=1, issue_count +2, split_count unchanged.
REQ-034 RAW: 0x003100B3 then 0x00508233 (add x4,x1,x5) -> cycle+1 dp1 only with 0x003100B3, cycle+2 dp2 only with 0x00508233, in_ready=0 at cycle+1, split_count=1.
REQ-035 WAW: 0x00500093 then 0x00700093 (both write x1) -> split, issued in order over two cycles.
REQ-036 x0: 0x00000013 then 0x00500233 -> no split, dual issue.
REQ-037 Stall in SPLIT for 3 cycles -> enables 0 for those cycles, then dp2 issues the held instr1; also n_rst pulsed in SPLIT -> no dp2 issue, all outputs at reset values.
REQ-038 Single instruction (instr1_valid=0) and counter limits: 65536 issues wrap issue_count to 0; 256 splits leave split_count at 0xFF.
